// File: rtl/error_message_display.sv
// Multiplexed seven-segment message display: latches a 3-bit code, scans DIGITS digits from a glyph ROM.
// Latency: a load applies at the next frame boundary (0 cycles if coincident); seg/dig_en registered, 1 cycle.
// Backpressure: none; a pending load is overwritten by newer loads and busy flags it until applied.
module error_message_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        msg_code,
  input  logic              msg_load,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_en,
  output logic              msg_ack,
  output logic              busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0]     FRM_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]        SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_POL  = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  // Load handshake: IDLE has nothing waiting, PEND holds a code until the frame boundary.
  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pre, pre_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [2:0]        code, code_nxt;
  logic [2:0]        pend_code, pend_nxt;
  logic [BW-1:0]     fcnt, fcnt_nxt;
  logic              phase, phase_nxt;
  logic              tick, frame, apply;
  logic [2:0]        idx3;
  logic [15:0]       line;
  logic [3:0]        ch;
  logic [6:0]        lit;
  logic [DIGITS-1:0] dig_lit;

  // Four characters per message, leftmost in [15:12]; digit i reads nibble i.
  // Char ids: 0-3 digits, 4 C, 5 E, 6 r, 7 S, 8 P, 9 '-', F blank.
  function automatic logic [15:0] msg_line(input logic [2:0] c);
    case (c)
      3'd1:    msg_line = 16'hF450;
      3'd2:    msg_line = 16'hF451;
      3'd3:    msg_line = 16'hF452;
      3'd4:    msg_line = 16'h5678;
      3'd5:    msg_line = 16'h56F0;
      3'd6:    msg_line = 16'h9999;
      3'd7:    msg_line = 16'hFF80;
      default: msg_line = 16'hFFFF;
    endcase
  endfunction

  // Lit segments, bit 6 = a down to bit 0 = g.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    glyph = 7'b1111110;
      4'h1:    glyph = 7'b0110000;
      4'h2:    glyph = 7'b1101101;
      4'h3:    glyph = 7'b1111001;
      4'h4:    glyph = 7'b1001110;
      4'h5:    glyph = 7'b1001111;
      4'h6:    glyph = 7'b0000101;
      4'h7:    glyph = 7'b1011011;
      4'h8:    glyph = 7'b1100111;
      4'h9:    glyph = 7'b0000001;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  // Prescaler and digit scan; a wrap of the digit index marks the frame boundary.
  always_comb begin
    tick    = (pre == PRE_LAST);
    frame   = tick && (idx == IDX_LAST);
    pre_nxt = tick ? '0 : pre + PW'(1);
    idx_nxt = idx;
    if (tick) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

  // Load handshake next state; a load in the boundary cycle bypasses the pending register.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_code;
    code_nxt  = code;
    apply     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (msg_load) begin
          if (frame) begin
            apply    = 1'b1;
            code_nxt = msg_code;
          end else begin
            state_nxt = ST_PEND;
            pend_nxt  = msg_code;
          end
        end
      end
      ST_PEND: begin
        if (msg_load) begin
          pend_nxt = msg_code;
        end
        if (frame) begin
          apply     = 1'b1;
          code_nxt  = msg_load ? msg_code : pend_code;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Blink phase toggles every BLINK_DIV frames and restarts whenever a message is applied.
  always_comb begin
    fcnt_nxt  = fcnt;
    phase_nxt = phase;
    if (apply) begin
      fcnt_nxt  = '0;
      phase_nxt = 1'b0;
    end else if (frame) begin
      if (fcnt == FRM_LAST) begin
        fcnt_nxt  = '0;
        phase_nxt = ~phase;
      end else begin
        fcnt_nxt = fcnt + BW'(1);
      end
    end
  end

  // Glyph for the digit about to be enabled, using the code and phase valid after this edge,
  // so the registered digit/segment pair never mixes old and new state.
  always_comb begin
    idx3    = 3'(idx_nxt);
    line    = msg_line(code_nxt);
    ch      = (idx3 > 3'd3) ? 4'hF : line[{idx3[1:0], 2'b00} +: 4];
    lit     = glyph(ch);
    if (blink_en && phase_nxt) begin
      lit = 7'b0000000;
    end
    dig_lit = DIGITS'(1) << idx_nxt;
  end

  // State registers; outputs refresh only on ticks and polarity is applied here alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pre       <= '0;
      idx       <= '0;
      code      <= '0;
      pend_code <= '0;
      fcnt      <= '0;
      phase     <= 1'b0;
      msg_ack   <= 1'b0;
      seg       <= SEG_POL;
      dig_en    <= DIGITS'(1) ^ DIG_POL;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      idx       <= idx_nxt;
      code      <= code_nxt;
      pend_code <= pend_nxt;
      fcnt      <= fcnt_nxt;
      phase     <= phase_nxt;
      msg_ack   <= apply;
      if (tick) begin
        seg    <= lit ^ SEG_POL;
        dig_en <= dig_lit ^ DIG_POL;
      end
    end
  end

  assign busy = (state == ST_PEND);

endmodule

// File: tb/tb_error_message_display.sv
// Bench for error_message_display: per-cycle scoreboard plus directed glyph/timing checks.
// A second instance covers two digits with active-high outputs.
module tb_error_message_display;

  localparam int S = 4;
  localparam int D = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] msg_code = '0;
  logic       msg_load = 1'b0;
  logic       blink_en = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       msg_ack, busy;

  logic [2:0] code2 = '0;
  logic       load2 = 1'b0;
  logic [6:0] seg2;
  logic [1:0] dig2;
  logic       ack2, busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  int ack2_cnt = 0;

  always #5 clk = ~clk;

  error_message_display #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B),
                          .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .msg_code(msg_code), .msg_load(msg_load),
    .blink_en(blink_en), .seg(seg), .dig_en(dig_en), .msg_ack(msg_ack), .busy(busy));

  error_message_display #(.DIGITS(2), .SCAN_DIV(S), .BLINK_DIV(B),
                          .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .msg_code(code2), .msg_load(load2),
    .blink_en(1'b0), .seg(seg2), .dig_en(dig2), .msg_ack(ack2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic string msg_text(input int c);
    case (c)
      1: return " CE0";
      2: return " CE1";
      3: return " CE2";
      4: return "ErSP";
      5: return "Er 0";
      6: return "----";
      7: return "  P0";
      default: return "    ";
    endcase
  endfunction

  function automatic logic [7:0] char_at(input int c, input int d);
    string s;
    if (d > 3) return " ";
    s = msg_text(c);
    return s[3-d];
  endfunction

  function automatic logic [6:0] lit_of(input logic [7:0] ch);
    case (ch)
      "0": return 7'b1111110;
      "1": return 7'b0110000;
      "2": return 7'b1101101;
      "3": return 7'b1111001;
      "C": return 7'b1001110;
      "E": return 7'b1001111;
      "r": return 7'b0000101;
      "S": return 7'b1011011;
      "P": return 7'b1100111;
      "-": return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference model for the 4-digit instance, driven by edge count since reset.
  int         n = 0;
  int         m_f = 0;
  logic [2:0] m_code = '0, m_pcode = '0;
  bit         m_pv = 0, m_busy = 0, m_ack = 0;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_dig = 4'b1110;
  logic [12:0] sb_q[$];
  logic [13:0] q2[$];
  logic [13:0] exp2 = '0;
  bit          have2 = 0;

  always @(posedge clk) begin
    int  idx;
    bit  applied;
    if (!rst_n) begin
      n = 0; m_code = 0; m_pv = 0; m_busy = 0; m_ack = 0; m_f = 0;
      m_seg = 7'h7F; m_dig = 4'b1110;
    end else begin
      n++;
      m_ack = 0;
      if (n % (S*D) == 0) begin
        applied = 1;
        if (msg_load) m_code = msg_code;
        else if (m_pv) m_code = m_pcode;
        else applied = 0;
        if (applied) begin
          m_f = 0;
          m_ack = 1;
        end else begin
          m_f++;
        end
        m_pv = 0;
        m_busy = 0;
      end else if (msg_load) begin
        m_pv = 1;
        m_pcode = msg_code;
        m_busy = 1;
      end
      if (n % S == 0) begin
        idx = (n / S) % D;
        m_dig = ~(4'b0001 << idx);
        m_seg = (blink_en && ((m_f / B) % 2 != 0)) ? 7'h7F : ~lit_of(char_at(int'(m_code), idx));
      end
    end
    sb_q.push_back({m_seg, m_dig, m_busy, m_ack});
  end

  always @(posedge clk) begin
    logic [12:0] e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("cyc", {seg, dig_en, busy, msg_ack}, e);
    end
    if (msg_ack) ack_cnt++;
    if (ack2) begin
      ack2_cnt++;
      if (q2.size() != 0) begin
        exp2  = q2.pop_front();
        have2 = 1;
      end
    end
  end

  task automatic wait_dig(input bit second, input logic [3:0] want, output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = second ? ({2'b00, dig2} == want) : (dig_en == want);
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = msg_ack;
    end
  endtask

  task automatic show_check(input string tag, input int c);
    bit         ok;
    logic [6:0] ex;
    for (int d = 0; d < 4; d++) begin
      wait_dig(0, ~(4'b0001 << d), ok);
      check({tag, "_dig"}, ok, 1);
      ex = ~lit_of(char_at(c, d));
      check({tag, "_seg"}, seg, ex);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         ok;
    int         base;
    int         a;
    logic [6:0] ex;

    #2 rst_n = 1'b0;
    #1;
    check("rst_seg", seg, 7'h7F);
    check("rst_dig", dig_en, 4'b1110);
    check("rst_busy", busy, 0);
    check("rst_ack", msg_ack, 0);
    check("rst_seg2", seg2, 7'h00);
    check("rst_dig2", dig2, 2'b01);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // second instance: load " CE2" right away
    code2 = 3'd3;
    load2 = 1'b1;
    q2.push_back({lit_of(char_at(3, 1)), lit_of(char_at(3, 0))});
    @(negedge clk);
    load2 = 1'b0;

    // idle scan for two frames
    repeat (32) @(negedge clk);
    check("d2_acks", ack2_cnt, 1);
    check("d2_popped", have2, 1);
    wait_dig(1, 4'b0001, ok);
    check("d2_wait0", ok, 1);
    check("d2_seg0", seg2, exp2[6:0]);
    wait_dig(1, 4'b0010, ok);
    check("d2_wait1", ok, 1);
    check("d2_seg1", seg2, exp2[13:7]);

    // load CE0 mid-frame
    while (n % 16 != 5) @(negedge clk);
    msg_code = 3'd1;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    check("ce0_busy", busy, 1);
    wait_ack(ok);
    check("ce0_ack", ok, 1);
    check("ce0_busy_clr", busy, 0);
    @(negedge clk);
    check("ce0_ack_1cyc", msg_ack, 0);
    show_check("ce0", 1);

    // two loads in one frame: only the last is applied, one ack
    base = ack_cnt;
    while (n % 16 != 3) @(negedge clk);
    msg_code = 3'd2;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    while (n % 16 != 7) @(negedge clk);
    msg_code = 3'd4;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    repeat (32) @(negedge clk);
    check("ovw_acks", ack_cnt - base, 1);
    show_check("ersp", 4);

    // load coincident with the wrap tick is applied at once
    while ((n + 1) % 16 != 0) @(negedge clk);
    msg_code = 3'd6;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    a = n;
    check("byp_busy", busy, 0);
    check("byp_ack", msg_ack, 1);
    blink_en = 1'b1;

    // blink: two visible frames, two dark frames, repeating
    for (int k = 0; k < 6; k++) begin
      while (n != a + 16*k + 2) @(negedge clk);
      check("blink_dig", dig_en, 4'b1110);
      ex = ((k % 4) >= 2) ? 7'h7F : ~lit_of("-");
      check("blink_seg", seg, ex);
    end
    blink_en = 1'b0;

    // reset mid-operation discards the pending load
    while (n % 16 != 6) @(negedge clk);
    msg_code = 3'd5;
    msg_load = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    check("rst2_busy_pre", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_seg", seg, 7'h7F);
    check("rst2_dig", dig_en, 4'b1110);
    check("rst2_busy", busy, 0);
    check("rst2_ack", msg_ack, 0);
    base = ack_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst2_noack", ack_cnt - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
